// File: rtl/deser_pkg.sv
// ============================================================================
// Module      : deser_pkg
// Description : Shared types and constants for the serial deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deser_pkg;

  // Receive FSM states; PAR is only reachable when the parity frame is built.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width: wide enough to hold WIDTH, covering the parity slot.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/deser_hold.sv
// ============================================================================
// Module      : deser_hold
// Description : One-entry parallel holding register with valid/ready
//               handshake and sticky overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             done_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             perr_i,
  input  logic             pready_i,
  output logic [WIDTH-1:0] pout_o,
  output logic             pvalid_o,
  output logic             perr_o,
  output logic             ovr_o
);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             w_consume;

  assign w_consume = pvalid_q & pready_i;

  // Next-state: consume, load a completed word, or flag a dropped word.
  always_comb begin
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    perr_d   = perr_q;
    ovr_d    = ovr_q;
    if (w_consume) begin
      pvalid_d = 1'b0;
    end
    if (done_i) begin
      // A slot being drained on this same edge counts as free.
      if (!pvalid_q || w_consume) begin
        pout_d   = data_i;
        perr_d   = perr_i;
        pvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clr_i) begin
      ovr_d = 1'b0;
    end
  end

  // Holding register state with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign pout_o   = pout_q;
  assign pvalid_o = pvalid_q;
  assign perr_o   = perr_q;
  assign ovr_o    = ovr_q;

endmodule

`default_nettype wire

// File: rtl/serial_deserializer.sv
// ============================================================================
// Module      : serial_deserializer
// Description : LSB-first serial-to-parallel receiver sharing the link bit
//               strobe SH. Assembles WIDTH-bit words and hands them to a
//               one-entry valid/ready output buffer with overrun flagging.
//               Define DESER_PARITY_EN to append and check an even-parity
//               bit per frame (PERR); otherwise PERR is always 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SIN,
  input  logic             SH,
  input  logic             CLR,
  output logic [WIDTH-1:0] POUT,
  output logic             PVALID,
  input  logic             PREADY,
  output logic             PERR,
  output logic             OVR,
  output logic             BUSY
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME - 1);
`ifdef DESER_PARITY_EN
  localparam logic [CW-1:0]  LAST_DAT = CW'(WIDTH - 1);
`endif

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             busy_q, busy_d;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  // Receive FSM, bit counter and shift register next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    w_done  = 1'b0;
    w_word  = sreg_q;
    w_perr  = 1'b0;
    if (CLR) begin
      // Realign wins over a simultaneous strobe; that bit is discarded.
      cnt_d   = '0;
      state_d = IDLE;
    end else if (SH) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
`ifdef DESER_PARITY_EN
      if (state_q == PAR) begin
        // Parity bit is checked but never shifted into the data word.
        w_done  = 1'b1;
        w_perr  = ^{sreg_q, SIN};
        state_d = IDLE;
      end else begin
        sreg_d  = {SIN, sreg_q[WIDTH-1:1]};
        state_d = (cnt_q == LAST_DAT) ? PAR : RECV;
      end
`else
      sreg_d = {SIN, sreg_q[WIDTH-1:1]};
      w_word = sreg_d;
      if (cnt_q == LAST_CNT) begin
        w_done  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = RECV;
      end
`endif
    end
    // IDLE is exactly the zero-count state, so BUSY follows the FSM.
    busy_d = (state_d != IDLE);
  end

  // Receive-side state registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      busy_q  <= busy_d;
    end
  end

  deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr_i    (CLR),
    .done_i   (w_done),
    .data_i   (w_word),
    .perr_i   (w_perr),
    .pready_i (PREADY),
    .pout_o   (POUT),
    .pvalid_o (PVALID),
    .perr_o   (PERR),
    .ovr_o    (OVR)
  );

  assign BUSY = busy_q;

endmodule

`default_nettype wire

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel receiver for the LSB-first shift link driven by the team's 8-bit parallel-load shift register. Shares the link's bit strobe, samples one serial bit per strobed clock edge, assembles a word and presents it on a one-entry parallel output buffer with a valid/ready handshake. Flags overrun when a completed word cannot be buffered. Sits at the far end of the serial link, feeding the downstream parallel consumer.

## Interface
- WIDTH, 8, data bits per word (≥2)
- CLK  input  1  rising-edge clock
- RST_N  input  1  reset; asynchronous assertion, active-low
- SIN  input  1  serial data, LSB first
- SH  input  1  bit strobe; SIN is sampled on a rising CLK edge while SH=1
- CLR  input  1  synchronous realign: discard partial word, clear OVR
- POUT  output  WIDTH  received word (holding register)
- PVALID  output  1  POUT holds an unconsumed word
- PREADY  input  1  consumer accepts POUT when PVALID=1 at a rising edge
- PERR  output  1  parity error for the word in POUT (0 without the parity feature)
- OVR  output  1  sticky overrun flag
- BUSY  output  1  partial word in progress (bit count ≠ 0)

## Operation
- Shift register: on a sampled bit, sreg ← {SIN, sreg[WIDTH-1:1]}; the first bit received lands in POUT[0].
- Bit counter 0..FRAME-1, where FRAME = WIDTH (WIDTH+1 with parity); wraps to 0 on the last bit.
- FSM: IDLE (count=0, no partial word) → RECV on the first sampled bit; RECV → PAR after the WIDTH-th bit (parity builds only); RECV/PAR → IDLE on the final bit of the frame.
- Word completion, on the edge sampling the final bit:
  - holding register is empty, or is being consumed on the same edge (PVALID & PREADY): load POUT and PERR, PVALID=1.
  - otherwise: drop the new word, keep POUT unchanged, set OVR.
- Handshake: PVALID & PREADY at an edge clears PVALID unless a new word loads on the same edge, in which case PVALID stays 1 with the new data.
- CLR: count←0, state←IDLE, OVR←0. It has priority over a simultaneous SH, and that bit is discarded. The holding register, PVALID and PERR are unaffected.
- SH=0: shift register, counter and FSM all hold; gaps between bits are unlimited.
- Reset values: POUT=0, PVALID=0, PERR=0, OVR=0, BUSY=0; shift register=0, count=0, state IDLE. Reset mid-word discards the partial word.

## Timing
- Capture: SIN is sampled on the same edge on which the transmitter advances. Wiring the same SH to both ends gives exact bit alignment after a transmitter LD.
- Latency: PVALID is high in the cycle immediately after the edge that sampled the final frame bit. There is no additional pipeline stage.
- Throughput: one word per FRAME strobed cycles, with back-to-back frames. This is lossless provided PREADY is asserted at the latest on the final-bit edge of the following frame.
- OVR sets on the edge of the dropped word and stays set until CLR or reset.
- BUSY is registered. It is 1 from the edge after the first bit through the edge of the final bit.

## Configuration
- DESER_PARITY_EN defined:
  - Frame is WIDTH data bits followed by one even-parity bit.
  - PERR = 1 when XOR(data, parity bit) ≠ 0. PERR is stored alongside POUT and is valid while PVALID=1.
  - A word with bad parity is still delivered.
- DESER_PARITY_EN undefined:
  - Frame is WIDTH bits, the PAR state is absent and PERR is tied to 0.

## Structure
- Package deser_pkg:
  - state enum typedef (IDLE, RECV, PAR)
  - default WIDTH constant
  - counter-width function $clog2(WIDTH+1)
- Sub-module deser_hold: the one-entry holding register with PVALID/PREADY and overrun detection. It takes a word-complete pulse, data and parity status, and outputs POUT/PVALID/PERR/OVR.

## Test plan
- Reset, then 8 strobed bits 1,0,1,0,0,1,1,0 (LSB first) → POUT=8'h65, PVALID=1 the cycle after the 8th bit, BUSY=0.
- Loopback from the shift-register transmitter: LD PIN=8'hA5, then 8 SH cycles → POUT=8'hA5. SH gaps of 0–3 idle cycles between bits give the same result.
- Hold PREADY=0 and send two words 8'h11, 8'h22 → POUT stays 8'h11, OVR=1. Then PREADY=1 for one cycle → PVALID=0. CLR → OVR=0.
- Consume on the completion edge: PVALID=1 with 8'h33, PREADY=1 on the final-bit edge of 8'h44 → POUT=8'h44, PVALID stays 1, OVR=0.
- Send 3 bits, pulse CLR together with SH, then send 8'hC3 → POUT=8'hC3. Repeat with RST_N low mid-word → all outputs 0.
- DESER_PARITY_EN: 8'h07 with parity bit 1 → PERR=0. The same word with parity bit 0 → PERR=1, PVALID=1.
